// File: rtl/anomaly_alarm_manager_pkg.sv
// Shared definitions for the anomaly alarm manager: FSM encoding, parameter
// defaults and the saturating event counter helper.
package anomaly_alarm_manager_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } alarm_state_e;

  localparam int DEF_WINDOW      = 16;
  localparam int DEF_ALARM_TH    = 4;
  localparam int DEF_CLEAR_TH    = 1;
  localparam int DEF_HOLD_CYCLES = 64;
  localparam int EVT_CNT_W       = 16;

  // Sticks at all-ones instead of wrapping.
  function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/anomaly_alarm_manager_window_counter.sv
// Sliding-window history of evaluation results with a running anomaly count
// that always equals the popcount of the history register.
module anomaly_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  logic [WINDOW-1:0] r_hist;
  logic [CNT_W-1:0]  r_count;
  logic              w_oldest;

  assign w_oldest = r_hist[WINDOW-1];
  assign count    = r_count;

  // The bit leaving the window is subtracted as the new one enters, so the
  // count can never leave 0..WINDOW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_hist  <= '0;
      r_count <= '0;
    end else if (shift_en) begin
      r_hist  <= {r_hist[WINDOW-2:0], bit_in};
      r_count <= r_count + CNT_W'(bit_in) - CNT_W'(w_oldest);
    end
  end

endmodule

// File: rtl/anomaly_alarm_manager.sv
// Debounced, hysteretic alarm over a sliding window of anomaly results, with
// minimum hold time, raise interrupt pulse, sticky latch and event counter.
module anomaly_alarm_manager
  import anomaly_alarm_manager_pkg::*;
#(
  parameter  int WINDOW      = DEF_WINDOW,
  parameter  int ALARM_TH    = DEF_ALARM_TH,
  parameter  int CLEAR_TH    = DEF_CLEAR_TH,
  parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 eval_valid,
  input  logic                 anomaly_in,
  input  logic                 alarm_ack,
  output logic                 alarm,
  output logic                 alarm_irq,
  output logic                 alarm_latched,
  output logic [CNT_W-1:0]     window_count,
  output logic [EVT_CNT_W-1:0] total_events
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  ALARM_TH_C = CNT_W'(ALARM_TH);
  localparam logic [CNT_W-1:0]  CLEAR_TH_C = CNT_W'(CLEAR_TH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

  alarm_state_e          r_state;
  alarm_state_e          w_state_next;
  logic                  w_raise;
  logic                  w_shift;
  logic [CNT_W-1:0]      w_count;
  logic [HOLD_W-1:0]     r_hold;
  logic                  r_irq;
  logic                  r_latched;
  logic [EVT_CNT_W-1:0]  r_total;

  assign w_shift = enable & eval_valid;

  anomaly_window_counter #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_window (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (~enable),
    .shift_en (w_shift),
    .bit_in   (anomaly_in),
    .count    (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Decisions look at the registered count, so a raise lands one edge after
  // the evaluation that crossed the threshold was sampled.
  always_comb begin
    w_state_next = r_state;
    w_raise      = 1'b0;
    if (!enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = MONITOR;
        MONITOR: begin
          if (w_count >= ALARM_TH_C) begin
            w_state_next = ALARM;
            w_raise      = 1'b1;
          end
        end
        ALARM:   begin
          if (r_hold == '0 && w_count <= CLEAR_TH_C) w_state_next = MONITOR;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold    <= '0;
      r_irq     <= 1'b0;
      r_latched <= 1'b0;
      r_total   <= '0;
    end else begin
      if (!enable)                             r_hold <= '0;
      else if (w_raise)                        r_hold <= HOLD_LOAD;
      else if (r_state == ALARM && r_hold != '0) r_hold <= r_hold - 1'b1;

      r_irq <= w_raise;

      // A raise on the same edge as an ack keeps the latch set.
      if (w_raise)        r_latched <= 1'b1;
      else if (alarm_ack) r_latched <= 1'b0;

      if (w_shift && anomaly_in) r_total <= sat_inc(r_total);
    end
  end

  assign alarm         = (r_state == ALARM);
  assign alarm_irq     = r_irq;
  assign alarm_latched = r_latched;
  assign window_count  = w_count;
  assign total_events  = r_total;

endmodule

// File: tb/tb_anomaly_alarm_manager.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based behavioural model of the alarm rules.
module tb_anomaly_alarm_manager;

  localparam int WINDOW      = 16;
  localparam int ALARM_TH    = 4;
  localparam int CLEAR_TH    = 1;
  localparam int HOLD_CYCLES = 64;
  localparam int CNT_W       = $clog2(WINDOW + 1);
  localparam int VW          = 3 + CNT_W + 16;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             eval_valid;
  logic             anomaly_in;
  logic             alarm_ack;
  logic             alarm;
  logic             alarm_irq;
  logic             alarm_latched;
  logic [CNT_W-1:0] window_count;
  logic [15:0]      total_events;

  int n_pass;
  int n_total;

  // Behavioural model state
  int m_hist[$];
  int m_cyc;
  int m_raise_cyc;
  bit m_active;
  bit m_alarm;
  bit m_irq;
  bit m_latched;
  int m_total;

  anomaly_alarm_manager #(
    .WINDOW      (WINDOW),
    .ALARM_TH    (ALARM_TH),
    .CLEAR_TH    (CLEAR_TH),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .eval_valid    (eval_valid),
    .anomaly_in    (anomaly_in),
    .alarm_ack     (alarm_ack),
    .alarm         (alarm),
    .alarm_irq     (alarm_irq),
    .alarm_latched (alarm_latched),
    .window_count  (window_count),
    .total_events  (total_events)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int m_count();
    int s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    return s;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_alarm, m_irq, m_latched, CNT_W'(m_count()), 16'(m_total)};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {alarm, alarm_irq, alarm_latched, window_count, total_events};
  endfunction

  task automatic m_reset();
    m_hist = {};
    for (int i = 0; i < WINDOW; i++) m_hist.push_back(0);
    m_active = 0; m_alarm = 0; m_irq = 0; m_latched = 0; m_total = 0;
    m_raise_cyc = 0;
  endtask

  // One clock edge with the given inputs; the model advances using the
  // pre-edge window contents, as the alarm rules describe.
  task automatic step(input bit en, input bit v, input bit a, input bit ack);
    int pre;
    bit raise, fall;
    enable = en; eval_valid = v; anomaly_in = a; alarm_ack = ack;
    @(posedge clk);
    m_cyc++;
    pre   = m_count();
    raise = en && m_active && !m_alarm && (pre >= ALARM_TH);
    fall  = en && m_alarm && (m_cyc - m_raise_cyc >= HOLD_CYCLES) && (pre <= CLEAR_TH);
    if (en && v && a && m_total < 65535) m_total++;
    if (raise)    m_latched = 1;
    else if (ack) m_latched = 0;
    m_irq = raise;
    if (!en) begin
      m_alarm = 0; m_active = 0;
      foreach (m_hist[i]) m_hist[i] = 0;
    end else begin
      m_active = 1;
      if (raise) begin
        m_alarm = 1; m_raise_cyc = m_cyc;
      end else if (fall) begin
        m_alarm = 0;
      end
      if (v) begin
        m_hist.push_front(int'(a));
        void'(m_hist.pop_back());
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_prestream cyc=%0d got=%h exp=%h", m_cyc, obs_vec(), exp_vec());
      else n_pass++;
    end
    #3 reset_n = 1'b0;
    #1 m_reset();
    n_total++;
    if (obs_vec() !== '0) $display("FAIL reset_async got=%h exp=0", obs_vec());
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0);
      n_total++;
      if (obs_vec() !== exp_vec() || window_count !== '0 || alarm !== 1'b0)
        $display("FAIL reset_idle_zeros i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    $display("test_reset done");
  endtask

  task automatic test_raise();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0);
      n_total++;
      if (obs_vec() !== exp_vec() || window_count !== CNT_W'(i + 1) || alarm !== 1'b0)
        $display("FAIL raise_count i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    step(1, 0, 0, 0);
    n_total++;
    if (obs_vec() !== exp_vec() || {alarm, alarm_irq, alarm_latched} !== 3'b111 || total_events !== 16'd4)
      $display("FAIL raise_edge got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    step(1, 0, 0, 0);
    n_total++;
    if (obs_vec() !== exp_vec() || alarm_irq !== 1'b0 || alarm !== 1'b1)
      $display("FAIL raise_irq_single got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    $display("test_raise done");
  endtask

  task automatic test_hold();
    int high_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 0, 0);
      if (alarm) high_cycles++;
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL hold_decay i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if (alarm !== 1'b0 || high_cycles < HOLD_CYCLES - 2)
      $display("FAIL hold_min_time alarm=%b high=%0d exp_alarm=0", alarm, high_cycles);
    else n_pass++;
    // Hysteresis: park the window at a count of 2
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 150; i++) begin
      step(1, 0, 0, 0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL hyst_hold i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if (alarm !== 1'b1 || window_count !== CNT_W'(2))
      $display("FAIL hyst_level alarm=%b cnt=%0d exp alarm=1 cnt=2", alarm, window_count);
    else n_pass++;
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    n_total++;
    if (obs_vec() !== exp_vec() || alarm !== 1'b0)
      $display("FAIL hyst_release got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    $display("test_hold done");
  endtask

  task automatic test_window_wrap();
    int irqs = 0;
    step(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, (i % 2) == 0, 0);
      if (alarm_irq) irqs++;
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL wrap i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if (window_count !== CNT_W'(8) || irqs != 1 || alarm !== 1'b1)
      $display("FAIL wrap_steady cnt=%0d irqs=%0d alarm=%b exp cnt=8 irqs=1 alarm=1", window_count, irqs, alarm);
    else n_pass++;
    $display("test_window_wrap done");
  endtask

  task automatic test_ack_race();
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    n_total++;
    if (alarm_latched !== 1'b0 || alarm !== 1'b0)
      $display("FAIL ack_clear_idle latched=%b alarm=%b exp 0 0", alarm_latched, alarm);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    step(1, 0, 0, 1);
    n_total++;
    if (obs_vec() !== exp_vec() || alarm_latched !== 1'b1 || alarm_irq !== 1'b1)
      $display("FAIL ack_race got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    n_total++;
    if (obs_vec() !== exp_vec() || alarm_latched !== 1'b0 || alarm !== 1'b1)
      $display("FAIL ack_during_alarm got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    $display("test_ack_race done");
  endtask

  task automatic test_enable_low();
    int  tot_before;
    bit  lat_before;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    tot_before = m_total;
    lat_before = m_latched;
    step(0, 1, 1, 0);
    n_total++;
    if (obs_vec() !== exp_vec() || alarm !== 1'b0 || window_count !== '0 ||
        total_events !== 16'(tot_before) || alarm_latched !== lat_before)
      $display("FAIL enable_low got=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
    $display("test_enable_low done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 19) != 0, ($urandom % 4) != 0,
           $urandom_range(0, 99) < 35, ($urandom % 16) == 0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    $display("test_random done");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65540; i++) step(1, 1, 1, 0);
    n_total++;
    if (obs_vec() !== exp_vec() || total_events !== 16'hFFFF)
      $display("FAIL saturation got=%h exp=%h total=%h", obs_vec(), exp_vec(), total_events);
    else n_pass++;
    $display("test_saturation done");
  endtask

  initial begin
    n_pass = 0; n_total = 0; m_cyc = 0;
    reset_n = 1'b0; enable = 1'b0; eval_valid = 1'b0; anomaly_in = 1'b0; alarm_ack = 1'b0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    test_reset();
    test_raise();
    test_hold();
    test_window_wrap();
    test_ack_race();
    test_enable_low();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
